// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT bit-reversal reorder controller:
// FSM state encoding and a width-parameterised bit-reverse helper.
package fft_reorder_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int BITREV_MAX_W = 32;

  // Reverses the low w bits of v; bits at or above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] v,
    input int                      w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        r[5'(i)] = v[5'(w - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_skid2.sv
// Two-entry shift FIFO that holds {last, data} read back from the SRAM
// so a single-cycle read latency never loses a sample under backpressure.
module fft_reorder_skid2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] r_m0;
  logic [W-1:0] r_m1;
  logic [1:0]   r_occ;

  // r_m0 is always the head; a pop shifts r_m1 forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= 2'd0;
      r_m0  <= '0;
      r_m1  <= '0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (push) begin
            r_m0  <= din;
            r_occ <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            r_m0 <= din;
          end else if (push) begin
            r_m1  <= din;
            r_occ <= 2'd2;
          end else if (pop) begin
            r_occ <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            r_m0 <= r_m1;
            if (push) begin
              r_m1 <= din;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
        default: r_occ <= 2'd0;
      endcase
    end
  end

  assign dout = r_m0;
  assign occ  = r_occ;

endmodule

// File: rtl/fft_bitrev_reorder_ctrl.sv
// SRAM master that writes one frame in natural order and streams it back
// in bit-reversed address order through a 2-entry output skid.
module fft_bitrev_reorder_ctrl
  import fft_reorder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic                  r_rd_pend;
  logic                  r_rd_last;
  logic                  r_frame_err;

  logic                  w_fill_acc;
  logic                  w_rd_issue;
  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [2:0]            w_slots;
  logic [2:0]            w_limit;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH:0]   w_head;

  assign in_ready   = rst_n && (r_state == ST_FILL);
  assign w_fill_acc = in_ready && in_valid;
  assign w_pop      = out_valid && out_ready;

  // A head pop this cycle frees a slot, which keeps reads back-to-back
  // when the consumer never stalls.
  assign w_slots    = {1'b0, w_occ} + {2'b00, r_rd_pend};
  assign w_limit    = 3'd2 + {2'b00, w_pop};
  assign w_rd_issue = rst_n && (r_state == ST_DRAIN) && (w_slots < w_limit);
  assign w_rd_addr  = ADDR_WIDTH'(bitrev(BITREV_MAX_W'(r_rd_cnt), ADDR_WIDTH));

  always_comb begin
    sram_ce   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (w_fill_acc) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = r_wr_cnt;
      sram_din  = in_data;
    end else if (w_rd_issue) begin
      sram_ce   = 1'b1;
      sram_addr = w_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_last   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // The beat count decides the frame boundary; in_last is only audited.
      r_frame_err <= w_fill_acc && (in_last != (r_wr_cnt == LAST_IDX));
      r_rd_pend   <= w_rd_issue;
      r_rd_last   <= w_rd_issue && (r_rd_cnt == LAST_IDX);
      if (w_fill_acc) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_wr_cnt == LAST_IDX) begin
          r_state <= ST_DRAIN;
        end
      end
      if (w_rd_issue) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (r_rd_cnt == LAST_IDX) begin
          r_state <= ST_FILL;
        end
      end
    end
  end

  fft_reorder_skid2 #(
    .W(DATA_WIDTH + 1)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .push (r_rd_pend),
    .din  ({r_rd_last, sram_dout}),
    .pop  (w_pop),
    .dout (w_head),
    .occ  (w_occ)
  );

  assign out_valid = (w_occ != 2'd0);
  assign out_last  = w_head[DATA_WIDTH];
  assign out_data  = w_head[DATA_WIDTH-1:0];
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft_bitrev_reorder_ctrl.sv
// Randomised bench for the bit-reversal reorder controller, scored against
// a frame-level model with a behavioural single-port SRAM per instance.
module tb_fft_bitrev_reorder_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int N  = 8;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last, frame_err, sram_ce, sram_we;
  logic [DW-1:0] out_data, sram_din, sram_dout;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] mem3 [N];

  logic          in1_valid = 1'b0, in1_last = 1'b0, out1_ready = 1'b1;
  logic [DW-1:0] in1_data = '0;
  logic          in1_ready, out1_valid, out1_last, frame1_err, sram1_ce, sram1_we;
  logic [DW-1:0] out1_data, sram1_din, sram1_dout;
  logic [0:0]    sram1_addr;
  logic [DW-1:0] mem1 [2];

  fft_bitrev_reorder_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  fft_bitrev_reorder_ctrl #(.ADDR_WIDTH(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_ready(in1_ready),
    .in_data(in1_data), .in_last(in1_last), .out_valid(out1_valid),
    .out_ready(out1_ready), .out_data(out1_data), .out_last(out1_last),
    .frame_err(frame1_err), .sram_ce(sram1_ce), .sram_we(sram1_we),
    .sram_addr(sram1_addr), .sram_din(sram1_din), .sram_dout(sram1_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem3[sram_addr] <= sram_din;
      else         sram_dout <= mem3[sram_addr];
    end
    if (sram1_ce) begin
      if (sram1_we) mem1[sram1_addr] <= sram1_din;
      else          sram1_dout <= mem1[sram1_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int brev(input int k, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  // Reference model state
  beat_t         in_q [$];
  beat_t         exp_q [$];
  logic [DW-1:0] cur_frame [$];
  logic [DW-1:0] got_q [$];
  int            t0_q [$];
  int wr_idx, rd_idx, out_idx, last_t0, drain_cnt, n_pops, n_err_seen;
  logic err_pend, prev_ov, stall_prev, stall_l, drain_stall;
  logic [DW-1:0] stall_d;

  task automatic model_flush();
    in_q.delete(); exp_q.delete(); cur_frame.delete();
    wr_idx = 0; rd_idx = 0; out_idx = 0; drain_cnt = 0; drain_stall = 1'b0;
    err_pend = 1'b0; prev_ov = 1'b0; stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0; out1_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_sram_ce", sram_ce, 0);
    check_eq("rst_sram_we", sram_we, 0);
    check_eq("rst_sram_addr", sram_addr, 0);
    check_eq("rst_sram_din", sram_din, 0);
    check_eq("rst_in_ready_held", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);
    model_flush();
  endtask

  // One clock cycle on the AW=3 instance: drive, score, then advance.
  task automatic cyc3(input logic want_valid, input logic ordy);
    beat_t b;
    b = '0;
    if (in_q.size() > 0) b = in_q[0];
    in_valid  = want_valid && (in_q.size() > 0);
    in_data   = in_valid ? b.d : '0;
    in_last   = in_valid ? b.l : 1'b0;
    out_ready = ordy;
    #1;
    check_eq("frame_err", frame_err, err_pend);
    if (frame_err) n_err_seen++;
    if (stall_prev) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, stall_d);
      check_eq("stall_last", out_last, stall_l);
    end
    if (out_valid && !prev_ov) check_eq("first_out_latency", cyc - last_t0, 3);
    if (out_idx != 0 && out_ready) check_eq("no_bubble", out_valid, 1);

    err_pend = 1'b0;
    if (in_valid && in_ready) begin
      check_eq("wr_ce_we", {sram_ce, sram_we}, 2'b11);
      check_eq("wr_addr", sram_addr, wr_idx);
      check_eq("wr_din", sram_din, in_data);
      err_pend = (in_last != (wr_idx == N - 1));
      cur_frame.push_back(in_data);
      void'(in_q.pop_front());
      wr_idx++;
      if (wr_idx == N) begin
        for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, cur_frame[brev(k, AW)]});
        cur_frame.delete();
        wr_idx  = 0;
        last_t0 = cyc;
        t0_q.push_back(cyc);
      end
    end else if (in_valid) begin
      check_eq("ignored_in_we", sram_we, 0);
    end
    if (sram_ce && !sram_we) begin
      check_eq("rd_addr", sram_addr, brev(rd_idx, AW));
      rd_idx = (rd_idx + 1) % N;
    end

    if (!in_ready) begin
      drain_cnt++;
      if (!out_ready) drain_stall = 1'b1;
    end else if (drain_cnt != 0) begin
      if (!drain_stall) check_eq("drain_len", drain_cnt, N);
      drain_cnt = 0;
      drain_stall = 1'b0;
    end

    if (out_valid && out_ready) begin
      n_pops++;
      got_q.push_back(out_data);
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        b = exp_q.pop_front();
        check_eq("out_data", out_data, b.d);
        check_eq("out_last", out_last, b.l);
        out_idx = b.l ? 0 : out_idx + 1;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_d    = out_data;
    stall_l    = out_last;
    prev_ov    = out_valid;
    @(negedge clk);
  endtask

  task automatic push_frame(input int base, input int last_mask);
    for (int k = 0; k < N; k++) in_q.push_back({last_mask[k], DW'(base + k)});
  endtask

  task automatic push_rand_frame();
    for (int k = 0; k < N; k++) in_q.push_back({k == N - 1, DW'($urandom)});
  endtask

  // out_mode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  task automatic run3(input int ncyc, input int in_mode, input int out_mode);
    logic iv, ordy;
    for (int i = 0; i < ncyc; i++) begin
      iv   = (in_mode == 0) ? 1'b1 : 1'(($urandom % 2) != 0);
      ordy = (out_mode == 0) ? 1'b1 :
             (out_mode == 1) ? ((i % 4) == 0 || (i % 4) == 3) :
                               1'(($urandom % 4) != 0);
      cyc3(iv, ordy);
    end
  endtask

  task automatic check_seq(input string tag, input int base);
    int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    check_eq({tag, "_count"}, got_q.size(), N);
    for (int k = 0; k < N && k < got_q.size(); k++)
      check_eq(tag, got_q[k], base + ord[k]);
  endtask

  initial begin
    int base;
    beat_t got1 [$];
    int b1;
    logic [DW-1:0] va, vb;

    n_pops = 0; n_err_seen = 0; last_t0 = 0;
    model_flush();
    do_reset();

    got_q.delete();
    push_frame(0, 8'h80);
    run3(30, 0, 0);
    check_seq("t1_order", 0);
    check_eq("t1_drained", exp_q.size(), 0);

    got_q.delete();
    push_frame(0, 8'h80);
    run3(50, 0, 1);
    check_seq("t2_order", 0);
    check_eq("t2_drained", exp_q.size(), 0);

    t0_q.delete();
    for (int f = 0; f < 3; f++) push_rand_frame();
    run3(70, 0, 0);
    check_eq("t3_frames", t0_q.size(), 3);
    for (int i = 0; i + 1 < t0_q.size(); i++)
      check_eq("t3_period", t0_q[i + 1] - t0_q[i], 2 * N);
    check_eq("t3_drained", exp_q.size(), 0);

    n_err_seen = 0;
    push_frame(16'h100, 8'h10);
    run3(30, 0, 0);
    check_eq("t4_err_pulses", n_err_seen, 2);
    check_eq("t4_drained", exp_q.size(), 0);

    push_frame(16'h20, 8'h80);
    base = n_pops;
    for (int i = 0; i < 60 && (n_pops - base) < 3; i++) cyc3(1'b1, 1'b1);
    check_eq("t5_reach_3rd_out", n_pops - base, 3);
    do_reset();
    got_q.delete();
    push_frame(10, 8'h80);
    run3(30, 0, 0);
    check_seq("t5_order", 10);
    check_eq("t5_drained", exp_q.size(), 0);

    for (int f = 0; f < 4; f++) push_rand_frame();
    run3(200, 1, 2);
    run3(60, 0, 0);
    check_eq("t6_inputs_used", in_q.size(), 0);
    check_eq("t6_drained", exp_q.size(), 0);

    va = DW'($urandom);
    vb = DW'($urandom);
    b1 = 0;
    for (int i = 0; i < 12; i++) begin
      in1_valid = (b1 < 2);
      in1_data  = (b1 == 0) ? va : vb;
      in1_last  = (b1 == 1);
      #1;
      if (frame1_err) check_eq("a1_frame_err", frame1_err, 0);
      if (in1_valid && in1_ready) b1++;
      if (out1_valid && out1_ready) got1.push_back({out1_last, out1_data});
      @(negedge clk);
    end
    in1_valid = 1'b0;
    check_eq("a1_count", got1.size(), 2);
    if (got1.size() == 2) begin
      check_eq("a1_first", got1[0], {1'b0, va});
      check_eq("a1_second", got1[1], {1'b1, vb});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
